// File: rtl/oraograph_fetch_scaler_if.sv
// Framebuffer read port, colour controls and video outputs of the scan-out engine.
// master = the scaler, slave = the memory/encoder side.
interface oraograph_fetch_scaler_if #(
    parameter int ADDR_W = 13,
    parameter int BPP    = 1
);
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rd;
    logic [7:0]        disp_data;
    logic [23:0]       fg_color;
    logic [23:0]       bg_color;
    logic [23:0]       border_color;
    logic              blank;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    logic              de;
    logic              hsync;
    logic              vsync;
    logic [BPP-1:0]    pix_index;
    logic              frame_start;

    modport master (
        output disp_addr, disp_rd, red, green, blue, de, hsync, vsync, pix_index, frame_start,
        input  disp_data, fg_color, bg_color, border_color, blank
    );
    modport slave (
        input  disp_addr, disp_rd, red, green, blue, de, hsync, vsync, pix_index, frame_start,
        output disp_data, fg_color, bg_color, border_color, blank
    );
endinterface

// File: rtl/oraograph_fetch_scaler.sv
// Framebuffer scan-out: video timing, byte fetch, pixel unpack with integer scaling
// inside a positioned window. All outputs lag the raster counters by RD_LATENCY+2.
module oraograph_fetch_scaler #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 1,
    parameter int FB_W       = 256,
    parameter int FB_H       = 240,
    parameter int BPP        = 1,
    parameter int SCALE_X    = 2,
    parameter int SCALE_Y    = 2,
    parameter int H_OFFSET   = 64,
    parameter int V_OFFSET   = 0,
    parameter int LSB_FIRST  = 1,
    parameter int ADDR_W     = 13,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk_pixel,
    input  logic                      reset,
    oraograph_fetch_scaler_if.master  bus
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CXW       = $clog2(H_TOTAL);
    localparam int CYW       = $clog2(V_TOTAL);
    localparam int PPB       = 8 / BPP;
    localparam int BPL       = FB_W * BPP / 8;
    localparam int WIN_W     = FB_W * SCALE_X;
    localparam int WIN_H     = FB_H * SCALE_Y;
    localparam int BYTE_SPAN = PPB * SCALE_X;
    localparam int P         = RD_LATENCY + 1;

    if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8) ||
        !(SCALE_X == 1 || SCALE_X == 2 || SCALE_X == 4) ||
        !(SCALE_Y == 1 || SCALE_Y == 2 || SCALE_Y == 4) ||
        BYTE_SPAN < 2 || RD_LATENCY < 1 || RD_LATENCY > 3 ||
        ((FB_W * BPP) % 8) != 0) begin : g_bad_cfg
        $error("oraograph_fetch_scaler: illegal parameter combination");
    end

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       win;
        logic       load;
        logic [2:0] bsel;
    } pix_t;

    logic [CXW-1:0]    cx_q, cx_d;
    logic [CYW-1:0]    cy_q, cy_d;
    logic              line_end;
    logic              blank_line_q;
    pix_t              s0;
    pix_t              pipe_q [P:1];
    pix_t              tail;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] disp_addr_q;
    logic              disp_rd_q;
    logic [7:0]        byte_q, cur_byte, grey;
    logic [BPP-1:0]    idx_w;
    int                cxi, cyi, wx, wy, fbx, fby, sh;

    logic [23:0]       rgb_q, rgb_d;
    logic [BPP-1:0]    idx_q, idx_d;
    logic              de_q, hs_q, vs_q, fs_q;

    assign line_end = (cx_q == CXW'(H_TOTAL - 1));

    always_comb begin
        cx_d = cx_q + 1'b1;
        cy_d = cy_q;
        if (line_end) begin
            cx_d = '0;
            cy_d = (cy_q == CYW'(V_TOTAL - 1)) ? '0 : cy_q + 1'b1;
        end
    end

    // Stage 0: classify the raster position and decide whether it opens a new byte.
    always_comb begin
        cxi = int'(cx_q);
        cyi = int'(cy_q);
        wx  = cxi - H_OFFSET;
        wy  = cyi - V_OFFSET;
        fbx = wx / SCALE_X;
        fby = wy / SCALE_Y;
        s0      = '0;
        s0.de   = (cxi < H_ACTIVE) && (cyi < V_ACTIVE);
        s0.hs   = (cxi >= H_ACTIVE + H_FP) && (cxi < H_ACTIVE + H_FP + H_SYNC);
        s0.vs   = (cyi >= V_ACTIVE + V_FP) && (cyi < V_ACTIVE + V_FP + V_SYNC);
        s0.fs   = (cxi == 0) && (cyi == 0);
        s0.win  = s0.de && !blank_line_q && (wx >= 0) && (wx < WIN_W) && (wy >= 0) && (wy < WIN_H);
        // A left-clipped window may start mid-byte, so column 0 also forces a fetch.
        s0.load = s0.win && (((wx % BYTE_SPAN) == 0) || (cxi == 0));
        s0.bsel = 3'(fbx % PPB);
        addr0   = ADDR_W'(fby * BPL + fbx / PPB);
    end

    assign tail     = pipe_q[P];
    assign cur_byte = tail.load ? bus.disp_data : byte_q;

    always_comb begin
        sh    = (LSB_FIRST != 0) ? int'(tail.bsel) * BPP : (PPB - 1 - int'(tail.bsel)) * BPP;
        idx_w = BPP'(cur_byte >> sh);
        grey  = {PPB{idx_w}};
        rgb_d = '0;
        idx_d = '0;
        if (tail.de && tail.win) begin
            idx_d = idx_w;
            rgb_d = (BPP == 1) ? (idx_w[0] ? bus.fg_color : bus.bg_color) : {3{grey}};
        end else if (tail.de) begin
            rgb_d = bus.border_color;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cx_q         <= '0;
            cy_q         <= '0;
            blank_line_q <= bus.blank;
            for (int k = 1; k <= P; k++) pipe_q[k] <= '0;
            disp_rd_q    <= 1'b0;
            disp_addr_q  <= '0;
            byte_q       <= '0;
            rgb_q        <= '0;
            idx_q        <= '0;
            de_q         <= 1'b0;
            hs_q         <= (SYNC_POL == 0);
            vs_q         <= (SYNC_POL == 0);
            fs_q         <= 1'b0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            if (line_end) blank_line_q <= bus.blank;
            pipe_q[1] <= s0;
            for (int k = 2; k <= P; k++) pipe_q[k] <= pipe_q[k-1];
            disp_rd_q <= s0.load;
            if (s0.load) disp_addr_q <= addr0;
            if (tail.load) byte_q <= bus.disp_data;
            rgb_q <= rgb_d;
            idx_q <= idx_d;
            de_q  <= tail.de;
            hs_q  <= (SYNC_POL != 0) ? tail.hs : ~tail.hs;
            vs_q  <= (SYNC_POL != 0) ? tail.vs : ~tail.vs;
            fs_q  <= tail.fs;
        end
    end

    assign bus.disp_addr   = disp_addr_q;
    assign bus.disp_rd     = disp_rd_q;
    assign bus.red         = rgb_q[23:16];
    assign bus.green       = rgb_q[15:8];
    assign bus.blue        = rgb_q[7:0];
    assign bus.pix_index   = idx_q;
    assign bus.de          = de_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_oraograph_fetch_scaler.sv
// Bench for oraograph_fetch_scaler on a shrunken raster, with a screen-position
// reference model, a latency-accurate memory responder and a per-line fetch scoreboard.
module tb_oraograph_fetch_scaler;
    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 24, VFP = 2, VS = 2, VBP = 3;
    localparam int SYNC_POL = 1;
    localparam int FBW = 32, FBH = 12, BPP = 2, SX = 1, SY = 2;
    localparam int HO = 40, VO = 4, LSB = 1, AW = 13, RDL = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int L  = RDL + 2;
    localparam int PPB = 8 / BPP;
    localparam int BPL = FBW * BPP / 8;
    localparam int VW = 28 + BPP;
    localparam logic [VW-1:0] RESETV = {1'b0, 1'(SYNC_POL == 0), 1'(SYNC_POL == 0), {(25+BPP){1'b0}}};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    oraograph_fetch_scaler_if #(.ADDR_W(AW), .BPP(BPP)) bus ();

    oraograph_fetch_scaler #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(SYNC_POL),
        .FB_W(FBW), .FB_H(FBH), .BPP(BPP), .SCALE_X(SX), .SCALE_Y(SY),
        .H_OFFSET(HO), .V_OFFSET(VO), .LSB_FIRST(LSB), .ADDR_W(AW), .RD_LATENCY(RDL)
    ) u_dut (
        .clk_pixel(clk),
        .reset(reset),
        .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Memory responder: data valid RDL cycles after the strobe, junk otherwise.
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] dpipe [0:2];
    logic       vpipe [0:2];
    logic [7:0] junk;
    always @(posedge clk) begin
        dpipe[0] <= mem[bus.disp_addr];
        vpipe[0] <= bus.disp_rd;
        for (int i = 1; i < 3; i++) begin
            dpipe[i] <= dpipe[i-1];
            vpipe[i] <= vpipe[i-1];
        end
        junk <= 8'($urandom);
    end
    assign bus.disp_data = vpipe[RDL-1] ? dpipe[RDL-1] : junk;

    // Reference model: expected outputs for the raster position j cycles after frame start.
    int ecount;
    bit lb [0:4095];
    logic [VW-1:0] exp_v;
    wire [VW-1:0] act_v = {bus.de, bus.hsync, bus.vsync, bus.frame_start,
                           bus.red, bus.green, bus.blue, bus.pix_index};

    function automatic logic [VW-1:0] model(int j, logic [23:0] fg, logic [23:0] bg, logic [23:0] bd);
        int ox, oy, wx, wy, fx, fy, sh, idx;
        logic de, hs, vs, fs, inw;
        logic [7:0] b;
        logic [23:0] rgb;
        ox = j % HT;
        oy = (j / HT) % VT;
        de = (ox < HA) && (oy < VA);
        hs = (ox >= HA + HFP) && (ox < HA + HFP + HS);
        vs = (oy >= VA + VFP) && (oy < VA + VFP + VS);
        if (SYNC_POL == 0) begin hs = !hs; vs = !vs; end
        fs = (ox == 0) && (oy == 0);
        wx = ox - HO;
        wy = oy - VO;
        inw = de && !lb[(j / HT) % 4096] && wx >= 0 && wx < FBW * SX && wy >= 0 && wy < FBH * SY;
        idx = 0;
        rgb = 24'h0;
        if (inw) begin
            fx = wx / SX;
            fy = wy / SY;
            b = mem[fy * BPL + fx * BPP / 8];
            sh = (LSB != 0) ? (fx % PPB) * BPP : (PPB - 1 - fx % PPB) * BPP;
            idx = (int'(b) >> sh) & ((1 << BPP) - 1);
            if (BPP == 1) rgb = (idx != 0) ? fg : bg;
            else rgb = {3{8'(idx * 255 / ((1 << BPP) - 1))}};
        end else if (de) begin
            rgb = bd;
        end
        return {de, hs, vs, fs, rgb, BPP'(idx)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ecount = 0;
            lb[0] = bus.blank;
            exp_v = RESETV;
        end else begin
            if (ecount % HT == HT - 1) lb[((ecount + 1) / HT) % 4096] = bus.blank;
            exp_v = (ecount - L + 1 < 0) ? RESETV :
                    model(ecount - L + 1, bus.fg_color, bus.bg_color, bus.border_color);
            ecount++;
        end
    end

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        checks += 8;
        if (bus.de !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", bus.de); end
        if (bus.hsync !== 1'(SYNC_POL == 0)) begin errors++; $display("FAIL reset_hsync got %b", bus.hsync); end
        if (bus.vsync !== 1'(SYNC_POL == 0)) begin errors++; $display("FAIL reset_vsync got %b", bus.vsync); end
        if ({bus.red, bus.green, bus.blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 0", {bus.red, bus.green, bus.blue}); end
        if (bus.pix_index !== '0) begin errors++; $display("FAIL reset_pix_index got %h want 0", bus.pix_index); end
        if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", bus.frame_start); end
        if (bus.disp_rd !== 1'b0) begin errors++; $display("FAIL reset_disp_rd got %b want 0", bus.disp_rd); end
        if (bus.disp_addr !== '0) begin errors++; $display("FAIL reset_disp_addr got %h want 0", bus.disp_addr); end
        reset = 1'b0;
    endtask

    task automatic test_timing();
        int de_c [2], hs_c [2], vs_c [2], fs_c [2];
        int j, f;
        for (int i = 0; i < 2; i++) begin de_c[i] = 0; hs_c[i] = 0; vs_c[i] = 0; fs_c[i] = 0; end
        do_reset();
        repeat (2 * FT + L) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL timing_pixel cycle %0d got %h want %h", ecount, act_v, exp_v); end
            j = ecount - L;
            if (j >= 0 && j < 2 * FT) begin
                f = j / FT;
                de_c[f] += int'(bus.de);
                hs_c[f] += int'(bus.hsync === 1'(SYNC_POL));
                vs_c[f] += int'(bus.vsync === 1'(SYNC_POL));
                fs_c[f] += int'(bus.frame_start && bus.de);
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks += 4;
            if (de_c[i] != HA * VA) begin errors++; $display("FAIL de_count frame %0d got %0d want %0d", i, de_c[i], HA * VA); end
            if (hs_c[i] != HS * VT) begin errors++; $display("FAIL hsync_count frame %0d got %0d want %0d", i, hs_c[i], HS * VT); end
            if (vs_c[i] != VS * HT) begin errors++; $display("FAIL vsync_count frame %0d got %0d want %0d", i, vs_c[i], VS * HT); end
            if (fs_c[i] != 1) begin errors++; $display("FAIL frame_start_count frame %0d got %0d want 1", i, fs_c[i]); end
        end
    endtask

    task automatic test_directed();
        int ox_t [7]  = '{39, 40, 41, 42, 43, 44, 64};
        logic [23:0] rgb_t [7] = '{24'h123456, 24'h000000, 24'h555555, 24'hAAAAAA, 24'hFFFFFF, 24'h000000, 24'h000000};
        int idx_t [7] = '{0, 0, 1, 2, 3, 0, 0};
        int target, n;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'h00;
        mem[0] = 8'hE4;
        bus.border_color = 24'h123456;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            target = VO * HT + ox_t[k];
            n = 0;
            while ((ecount - L) < target && n < 4 * FT) begin @(negedge clk); n++; end
            checks += 2;
            if ((ecount - L) != target) begin
                errors++; $display("FAIL directed_wait ox %0d reached %0d want %0d", ox_t[k], ecount - L, target);
            end else if ({bus.red, bus.green, bus.blue} !== rgb_t[k]) begin
                errors++; $display("FAIL directed_rgb ox %0d got %h want %h", ox_t[k], {bus.red, bus.green, bus.blue}, rgb_t[k]);
            end
            if (int'(bus.pix_index) != idx_t[k]) begin
                errors++; $display("FAIL directed_index ox %0d got %0d want %0d", ox_t[k], bus.pix_index, idx_t[k]);
            end
        end
    endtask

    task automatic test_pixels();
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'($urandom);
        do_reset();
        repeat (FT + L) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL pixel cycle %0d got %h want %h", ecount, act_v, exp_v); end
            if ($urandom_range(0, 15) == 0) begin
                bus.fg_color     = 24'($urandom);
                bus.bg_color     = 24'($urandom);
                bus.border_color = 24'($urandom);
            end
        end
    endtask

    task automatic test_fetch();
        int q [$];
        int cur_line, line, m, oy, wx, wy, a;
        logic [AW-1:0] last_addr;
        cur_line = -1;
        last_addr = '0;
        do_reset();
        repeat (FT + HT) begin
            @(negedge clk);
            m = ecount - 1;
            line = m / HT;
            if (line != cur_line) begin
                if (cur_line >= 0) begin
                    checks++;
                    if (q.size() != 0) begin errors++; $display("FAIL reads_per_line line %0d missing %0d reads want 0", cur_line, q.size()); end
                end
                q.delete();
                oy = line % VT;
                if (oy < VA && !lb[line % 4096]) begin
                    for (int ox = 0; ox < HA; ox++) begin
                        wx = ox - HO;
                        wy = oy - VO;
                        if (wx >= 0 && wx < FBW * SX && wy >= 0 && wy < FBH * SY) begin
                            a = (wy / SY) * BPL + (wx / SX) / PPB;
                            if (q.size() == 0 || q[$] != a) q.push_back(a);
                        end
                    end
                end
                cur_line = line;
            end
            checks++;
            if (bus.disp_rd === 1'b1) begin
                if (q.size() == 0) begin
                    errors++; $display("FAIL fetch_extra line %0d addr %0d want no read", line, bus.disp_addr);
                end else begin
                    if (int'(bus.disp_addr) != q[0]) begin
                        errors++; $display("FAIL fetch_addr line %0d got %0d want %0d", line, bus.disp_addr, q[0]);
                    end
                    void'(q.pop_front());
                end
                last_addr = bus.disp_addr;
            end else if (bus.disp_addr !== last_addr) begin
                errors++; $display("FAIL addr_hold line %0d got %0d want %0d", line, bus.disp_addr, last_addr);
            end
        end
    endtask

    task automatic test_blank();
        do_reset();
        repeat (FT) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL blank_pixel cycle %0d got %h want %h", ecount, act_v, exp_v); end
            if (lb[((ecount - 1) / HT) % 4096]) begin
                checks++;
                if (bus.disp_rd !== 1'b0) begin errors++; $display("FAIL blank_read cycle %0d got %b want 0", ecount, bus.disp_rd); end
            end
            if ($urandom_range(0, 59) == 0) bus.blank = ~bus.blank;
        end
        bus.blank = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int n, first_fs;
        do_reset();
        n = 0;
        while (ecount != 5 * HT + 30 && n < 2 * FT) begin
            @(negedge clk);
            n++;
            checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL pre_reset_pixel cycle %0d got %h want %h", ecount, act_v, exp_v); end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 3;
        if (act_v !== RESETV) begin errors++; $display("FAIL midreset_outputs got %h want %h", act_v, RESETV); end
        if (bus.disp_rd !== 1'b0) begin errors++; $display("FAIL midreset_disp_rd got %b want 0", bus.disp_rd); end
        if (bus.disp_addr !== '0) begin errors++; $display("FAIL midreset_disp_addr got %h want 0", bus.disp_addr); end
        first_fs = -1;
        repeat (FT + L + HT) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL post_reset_pixel cycle %0d got %h want %h", ecount, act_v, exp_v); end
            if (bus.frame_start === 1'b1 && first_fs < 0) first_fs = ecount;
        end
        checks++;
        if (first_fs != L) begin errors++; $display("FAIL first_frame_start at %0d want %0d", first_fs, L); end
    endtask

    initial begin
        reset = 1'b1;
        bus.blank = 1'b0;
        bus.fg_color = 24'hFFFFFF;
        bus.bg_color = 24'h000000;
        bus.border_color = 24'h202020;
        for (int i = 0; i < 3; i++) begin vpipe[i] = 1'b0; dpipe[i] = 8'h00; end
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'($urandom);
        test_reset();
        test_timing();
        test_directed();
        test_pixels();
        test_fetch();
        test_blank();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
